mem_stage_pipelined: RTL and testbench
======================================

Name: mem_stage_pipelined

Overview:
- Next-generation MIPS memory stage: byte-addressed data memory with byte-lane writes and a configurable read latency.
- Load stalls the pipeline upstream; misaligned accesses are detected; the MEM/WB register is internal.
- Debug read of data memory uses a request/valid handshake while the pipeline is disabled.
- Sits between the EX/MEM register and write-back; stall output feeds the hazard unit.

Parameters:
- PC_BITS, 32, width of the PC return value.
- PROC_BITS, 32, datapath word width; multiple of 8, ≥16. LANES = PROC_BITS/8, LB = log2(LANES).
- REG_ADDRS_BITS, 5, register-file address width.
- DATA_ADDRS_BITS, 10, word-address width; memory depth is 2^DATA_ADDRS_BITS words.
- MEM_LATENCY, 1, data memory read latency in cycles (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  pipeline enable; 0 = frozen/debug mode
- i_alu_data  in  PROC_BITS  byte address or ALU result
- i_store_data  in  PROC_BITS  store source (rt)
- i_rd  in  REG_ADDRS_BITS  destination register
- i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg  in  1 each  control
- i_ls_filter_op  in  3  [1:0]: 00 byte, 01 half, 11 word (10 treated as word); [2]=1 zero-extend loads
- i_pc_to_reg  in  1  link-instruction flag
- i_pc_return  in  PC_BITS  link address
- i_debug_read_req  in  1  debug read request
- i_debug_read_address  in  DATA_ADDRS_BITS  debug word address
- o_alu_data  out  PROC_BITS  registered ALU result
- o_mem_data  out  PROC_BITS  registered, filtered load data
- o_rd  out  REG_ADDRS_BITS  registered destination register
- o_RegWrite, o_MemtoReg, o_pc_to_reg  out  1 each  registered control
- o_pc_return  out  PC_BITS  registered link address
- o_stall  out  1  combinational; upstream holds while high
- o_misaligned  out  1  one-cycle pulse, registered
- o_debug_read_data  out  PROC_BITS  debug word
- o_debug_read_valid  out  1  one-cycle pulse

Behaviour:
- Reset: every output register is 0; o_stall=0; FSM goes to IDLE; counter is 0; memory contents are untouched. A reset mid-load or mid-debug aborts the operation with no write-back and no valid pulse.
- Address decode: word index = i_alu_data[DATA_ADDRS_BITS+LB-1:LB]; lane = i_alu_data[LB-1:0].
- Misalignment: half with addr[0]=1, or word with lane≠0. The access is then suppressed (no write, no load). Next cycle: o_misaligned=1, o_RegWrite=0, other fields pass through.
- FSM states: IDLE, LOAD, DBG. The FSM advances only when enable=1, except in DBG, which ignores enable.
- IDLE, enable=1, no memory op: MEM/WB register loads inputs on the edge (1-cycle latency).
- IDLE, aligned store: selected lanes are written on the edge. The store data byte/half is replicated to all lanes; only addressed lanes are enabled. No stall. The MEM/WB register loads normally.
- IDLE, aligned load: o_stall=1 combinationally; latch address, op and rd; cnt←1; go to LOAD. The MEM/WB register loads a bubble (RegWrite=MemtoReg=pc_to_reg=0).
- LOAD: o_stall = (cnt<MEM_LATENCY); cnt increments while stalled, with bubbles written.
  - When cnt==MEM_LATENCY: o_stall=0. Raw word is lane-shifted and sign/zero-extended per the latched op, then captured into o_mem_data with the latched rd/control; go to IDLE.
  - A load takes MEM_LATENCY+1 cycles total; stall is high for MEM_LATENCY cycles.
- enable=0 in IDLE/LOAD: the FSM, counter and MEM/WB register hold; no memory write; o_stall=0.
- Debug: accepted only in IDLE with enable=0 and i_debug_read_req=1; go to DBG.
  - After MEM_LATENCY cycles, o_debug_read_data = unfiltered word and o_debug_read_valid=1 for one cycle; return to IDLE.
  - o_debug_read_data holds until the next debug read.
  - Requests while enable=1 or FSM≠IDLE are ignored (the requester re-asserts).
- Simultaneous enable=1 and debug request: the pipeline wins.
- Writes never occur in DBG or LOAD.

Test Plan:
- Word store then load, MEM_LATENCY=2: sw 0xDEADBEEF @0x10; lw @0x10, rd=5 → o_stall high 2 cycles, then o_mem_data=0xDEADBEEF, o_rd=5, o_RegWrite=1; bubbles during stall.
- Byte lanes: sw 0x11223344 @0x20; sb 0xAA @0x21; lw @0x20 → 0x1122AA44. lb @0x21 → 0xFFFFFFAA; lbu @0x21 → 0x000000AA.
- Halfword sign: sh 0x8001 @0x32 → lh @0x32 = 0xFFFF8001, lhu = 0x00008001.
- Misaligned: lw @0x13 → no stall, o_misaligned pulse, o_RegWrite=0. sh @0x31 → memory unchanged on read-back.
- Debug: enable=0, req at word 4 holding 0xCAFEF00D → valid pulse exactly MEM_LATENCY cycles later with that data; a req with enable=1 yields no pulse.
- Reset mid-load: rst during LOAD → next cycle outputs 0, state IDLE, no valid write-back; earlier stored data still reads back correctly.

Source files
------------

// File: rtl/mem_stage_pipelined.sv
// MIPS memory stage: byte-lane data memory with configurable read latency,
// load stall generation, misalignment detection, internal MEM/WB register and debug read port.
module mem_stage_pipelined #(
    parameter int PC_BITS         = 32,
    parameter int PROC_BITS       = 32,
    parameter int REG_ADDRS_BITS  = 5,
    parameter int DATA_ADDRS_BITS = 10,
    parameter int MEM_LATENCY     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [PROC_BITS-1:0]       i_alu_data,
    input  logic [PROC_BITS-1:0]       i_store_data,
    input  logic [REG_ADDRS_BITS-1:0]  i_rd,
    input  logic                       i_RegWrite,
    input  logic                       i_MemRead,
    input  logic                       i_MemWrite,
    input  logic                       i_MemtoReg,
    input  logic [2:0]                 i_ls_filter_op,
    input  logic                       i_pc_to_reg,
    input  logic [PC_BITS-1:0]         i_pc_return,
    input  logic                       i_debug_read_req,
    input  logic [DATA_ADDRS_BITS-1:0] i_debug_read_address,
    output logic [PROC_BITS-1:0]       o_alu_data,
    output logic [PROC_BITS-1:0]       o_mem_data,
    output logic [REG_ADDRS_BITS-1:0]  o_rd,
    output logic                       o_RegWrite,
    output logic                       o_MemtoReg,
    output logic                       o_pc_to_reg,
    output logic [PC_BITS-1:0]         o_pc_return,
    output logic                       o_stall,
    output logic                       o_misaligned,
    output logic [PROC_BITS-1:0]       o_debug_read_data,
    output logic                       o_debug_read_valid
);
    localparam int LANES = PROC_BITS / 8;
    localparam int LB    = $clog2(LANES);
    localparam int DEPTH = 1 << DATA_ADDRS_BITS;
    localparam int CW    = $clog2(MEM_LATENCY + 1) + 1;
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DBG  = 2'd2;

    logic [LANES-1:0][7:0]      r_mem [DEPTH];
    logic [PROC_BITS-1:0]       r_rd_word;
    logic [1:0]                 r_state;
    logic [CW-1:0]              r_cnt;
    logic [DATA_ADDRS_BITS-1:0] r_addr;
    logic [LB-1:0]              r_lane;
    logic [2:0]                 r_op;
    logic [REG_ADDRS_BITS-1:0]  r_ld_rd;
    logic                       r_ld_regwrite, r_ld_memtoreg, r_ld_pc_to_reg;
    logic [PROC_BITS-1:0]       r_ld_alu;
    logic [PC_BITS-1:0]         r_ld_pc;

    logic [DATA_ADDRS_BITS-1:0] w_idx, w_rd_idx;
    logic [LB-1:0]              w_lane;
    logic                       w_mis, w_go, w_store, w_load;
    logic [LANES-1:0]           w_be;
    logic [LANES-1:0][7:0]      w_wdata;
    logic [PROC_BITS-1:0]       w_sh, w_ld_val;

    assign w_idx   = i_alu_data[DATA_ADDRS_BITS+LB-1:LB];
    assign w_lane  = i_alu_data[LB-1:0];
    assign w_mis   = (i_MemRead | i_MemWrite) &
                     ((i_ls_filter_op[1:0] == 2'b01 & i_alu_data[0]) |
                      (i_ls_filter_op[1] & (w_lane != '0)));
    assign w_go    = (r_state == S_IDLE) & enable;
    assign w_store = w_go & i_MemWrite & ~w_mis;
    assign w_load  = w_go & i_MemRead & ~w_mis;
    assign o_stall = w_load | ((r_state == S_LOAD) & enable & (r_cnt < LAT));

    // The read port follows the incoming address while idle so a 1-cycle latency still works.
    assign w_rd_idx = (r_state != S_IDLE) ? r_addr :
                      (enable ? w_idx : i_debug_read_address);

    // Narrow stores replicate the datum to every lane; the byte enables pick the target.
    always_comb begin
        w_be    = '0;
        w_wdata = i_store_data;
        if (i_ls_filter_op[1]) begin
            w_be = '1;
        end else if (i_ls_filter_op[0]) begin
            w_be    = LANES'(3) << w_lane;
            w_wdata = {(LANES/2){i_store_data[15:0]}};
        end else begin
            w_be    = LANES'(1) << w_lane;
            w_wdata = {LANES{i_store_data[7:0]}};
        end
    end

    assign w_sh = r_rd_word >> {r_lane, 3'b000};

    always_comb begin
        w_ld_val = w_sh;
        if (!r_op[1]) begin
            if (r_op[0]) w_ld_val = {{(PROC_BITS-16){~r_op[2] & w_sh[15]}}, w_sh[15:0]};
            else         w_ld_val = {{(PROC_BITS-8){~r_op[2] & w_sh[7]}}, w_sh[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            if (w_store && w_be[l]) r_mem[w_idx][l] <= w_wdata[l];
        r_rd_word <= r_mem[w_rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_addr             <= '0;
            r_lane             <= '0;
            r_op               <= '0;
            r_ld_rd            <= '0;
            r_ld_regwrite      <= 1'b0;
            r_ld_memtoreg      <= 1'b0;
            r_ld_pc_to_reg     <= 1'b0;
            r_ld_alu           <= '0;
            r_ld_pc            <= '0;
            o_alu_data         <= '0;
            o_mem_data         <= '0;
            o_rd               <= '0;
            o_RegWrite         <= 1'b0;
            o_MemtoReg         <= 1'b0;
            o_pc_to_reg        <= 1'b0;
            o_pc_return        <= '0;
            o_misaligned       <= 1'b0;
            o_debug_read_data  <= '0;
            o_debug_read_valid <= 1'b0;
        end else begin
            o_misaligned       <= 1'b0;
            o_debug_read_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        o_alu_data   <= i_alu_data;
                        o_rd         <= i_rd;
                        o_pc_return  <= i_pc_return;
                        o_misaligned <= w_mis;
                        if (w_load) begin
                            o_RegWrite     <= 1'b0;
                            o_MemtoReg     <= 1'b0;
                            o_pc_to_reg    <= 1'b0;
                            r_addr         <= w_idx;
                            r_lane         <= w_lane;
                            r_op           <= i_ls_filter_op;
                            r_ld_rd        <= i_rd;
                            r_ld_regwrite  <= i_RegWrite;
                            r_ld_memtoreg  <= i_MemtoReg;
                            r_ld_pc_to_reg <= i_pc_to_reg;
                            r_ld_alu       <= i_alu_data;
                            r_ld_pc        <= i_pc_return;
                            r_cnt          <= CW'(1);
                            r_state        <= S_LOAD;
                        end else begin
                            o_RegWrite  <= i_RegWrite & ~w_mis;
                            o_MemtoReg  <= i_MemtoReg;
                            o_pc_to_reg <= i_pc_to_reg;
                        end
                    end else if (i_debug_read_req) begin
                        r_addr  <= i_debug_read_address;
                        r_cnt   <= CW'(1);
                        r_state <= S_DBG;
                    end
                end
                S_LOAD: begin
                    if (enable) begin
                        if (r_cnt < LAT) begin
                            r_cnt       <= r_cnt + CW'(1);
                            o_RegWrite  <= 1'b0;
                            o_MemtoReg  <= 1'b0;
                            o_pc_to_reg <= 1'b0;
                        end else begin
                            o_mem_data  <= w_ld_val;
                            o_alu_data  <= r_ld_alu;
                            o_rd        <= r_ld_rd;
                            o_pc_return <= r_ld_pc;
                            o_RegWrite  <= r_ld_regwrite;
                            o_MemtoReg  <= r_ld_memtoreg;
                            o_pc_to_reg <= r_ld_pc_to_reg;
                            r_cnt       <= '0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_DBG: begin
                    if (r_cnt < LAT) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        o_debug_read_data  <= r_rd_word;
                        o_debug_read_valid <= 1'b1;
                        r_cnt              <= '0;
                        r_state            <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Self-checking bench: directed scenarios plus randomized loads/stores against a byte-array memory model.
module tb_mem_stage_pipelined;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [31:0] i_alu_data, i_store_data, i_pc_return;
    logic [4:0]  i_rd;
    logic        i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_pc_to_reg;
    logic [2:0]  i_ls_filter_op;
    logic        i_debug_read_req;
    logic [9:0]  i_debug_read_address;
    logic [31:0] o_alu_data, o_mem_data, o_pc_return, o_debug_read_data;
    logic [4:0]  o_rd;
    logic        o_RegWrite, o_MemtoReg, o_pc_to_reg, o_stall, o_misaligned, o_debug_read_valid;

    int tests_run = 0;
    int failed = 0;
    logic [7:0] m [4096];

    always #5 clk = ~clk;

    mem_stage_pipelined #(.PC_BITS(32), .PROC_BITS(32), .REG_ADDRS_BITS(5),
                          .DATA_ADDRS_BITS(10), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .i_alu_data(i_alu_data), .i_store_data(i_store_data), .i_rd(i_rd),
        .i_RegWrite(i_RegWrite), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
        .i_MemtoReg(i_MemtoReg), .i_ls_filter_op(i_ls_filter_op),
        .i_pc_to_reg(i_pc_to_reg), .i_pc_return(i_pc_return),
        .i_debug_read_req(i_debug_read_req), .i_debug_read_address(i_debug_read_address),
        .o_alu_data(o_alu_data), .o_mem_data(o_mem_data), .o_rd(o_rd),
        .o_RegWrite(o_RegWrite), .o_MemtoReg(o_MemtoReg), .o_pc_to_reg(o_pc_to_reg),
        .o_pc_return(o_pc_return), .o_stall(o_stall), .o_misaligned(o_misaligned),
        .o_debug_read_data(o_debug_read_data), .o_debug_read_valid(o_debug_read_valid)
    );

    function automatic int nbytes(input logic [2:0] op);
        return op[1] ? 4 : (op[0] ? 2 : 1);
    endfunction

    function automatic logic is_mis(input logic [31:0] a, input logic [2:0] op);
        return (a % nbytes(op)) != 0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        if (!is_mis(a, op))
            for (int i = 0; i < nbytes(op); i++) m[12'(a + i)] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] op);
        logic [31:0] v;
        int n;
        n = nbytes(op);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = m[12'(a + i)];
        if (n == 1 && !op[2]) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && !op[2]) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic set_nop();
        enable = 1'b1; i_alu_data = '0; i_store_data = '0; i_pc_return = '0; i_rd = '0;
        i_RegWrite = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0; i_MemtoReg = 1'b0;
        i_pc_to_reg = 1'b0; i_ls_filter_op = 3'b011; i_debug_read_req = 1'b0;
        i_debug_read_address = '0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        i_alu_data = a; i_store_data = d; i_ls_filter_op = op;
        i_MemWrite = 1'b1; i_MemRead = 1'b0; i_RegWrite = 1'b0; i_MemtoReg = 1'b0;
        #1;
        tests_run++;
        if (o_stall !== 1'b0) begin
            failed++; $display("FAIL store_no_stall a=%h got %b want 0", a, o_stall);
        end
        @(negedge clk);
        set_nop();
        model_write(a, d, op);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] op, input logic [4:0] rd,
                           input logic [31:0] exp, input string nm);
        int ns;
        i_alu_data = a; i_ls_filter_op = op; i_rd = rd;
        i_MemRead = 1'b1; i_MemWrite = 1'b0; i_RegWrite = 1'b1; i_MemtoReg = 1'b1;
        ns = 0;
        #1;
        while (o_stall === 1'b1 && ns < 20) begin
            ns++;
            @(negedge clk); #1;
            tests_run++;
            if (o_RegWrite !== 1'b0 || o_MemtoReg !== 1'b0) begin
                failed++; $display("FAIL %s bubble got rw=%b mtr=%b want 0", nm, o_RegWrite, o_MemtoReg);
            end
        end
        tests_run++;
        if (ns != L) begin
            failed++; $display("FAIL %s stall_cycles got %0d want %0d", nm, ns, L);
        end
        @(negedge clk);
        set_nop();
        tests_run++;
        if (o_mem_data !== exp || o_rd !== rd || o_RegWrite !== 1'b1 || o_MemtoReg !== 1'b1) begin
            failed++;
            $display("FAIL %s data got %h rd=%0d rw=%b want %h rd=%0d rw=1", nm, o_mem_data, o_rd, o_RegWrite, exp, rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; set_nop();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({o_alu_data, o_mem_data, o_rd, o_RegWrite, o_MemtoReg, o_pc_to_reg, o_pc_return,
             o_stall, o_misaligned, o_debug_read_data, o_debug_read_valid} !== '0) begin
            failed++; $display("FAIL reset_state got alu=%h mem=%h rw=%b stall=%b want all 0", o_alu_data, o_mem_data, o_RegWrite, o_stall);
        end
    endtask

    task automatic test_passthru();
        logic [31:0] a, pc;
        a = $urandom; pc = $urandom;
        i_alu_data = a; i_pc_return = pc; i_rd = 5'd17; i_RegWrite = 1'b1; i_pc_to_reg = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_alu_data !== a || o_pc_return !== pc || o_rd !== 5'd17 || o_RegWrite !== 1'b1 || o_pc_to_reg !== 1'b1) begin
            failed++; $display("FAIL passthru got alu=%h pc=%h rd=%0d want %h %h 17", o_alu_data, o_pc_return, o_rd, a, pc);
        end
        enable = 1'b0; i_alu_data = ~a; i_rd = 5'd3;
        @(negedge clk);
        tests_run++;
        if (o_alu_data !== a || o_rd !== 5'd17) begin
            failed++; $display("FAIL frozen_hold got alu=%h rd=%0d want %h 17", o_alu_data, o_rd, a);
        end
        set_nop();
    endtask

    task automatic test_word_and_lanes();
        do_store(32'h10, 32'hDEADBEEF, 3'b011);
        do_load(32'h10, 3'b011, 5'd5, 32'hDEADBEEF, "lw_word");
        do_store(32'h20, 32'h11223344, 3'b011);
        do_store(32'h21, 32'h000000AA, 3'b000);
        do_load(32'h20, 3'b011, 5'd6, 32'h1122AA44, "lw_lanes");
        do_load(32'h21, 3'b000, 5'd7, 32'hFFFFFFAA, "lb");
        do_load(32'h21, 3'b100, 5'd8, 32'h000000AA, "lbu");
        do_store(32'h32, 32'h00008001, 3'b001);
        do_load(32'h32, 3'b001, 5'd9, 32'hFFFF8001, "lh");
        do_load(32'h32, 3'b101, 5'd10, 32'h00008001, "lhu");
    endtask

    task automatic test_misaligned();
        i_alu_data = 32'h13; i_ls_filter_op = 3'b011; i_rd = 5'd4;
        i_MemRead = 1'b1; i_RegWrite = 1'b1; i_MemtoReg = 1'b1;
        #1;
        tests_run++;
        if (o_stall !== 1'b0) begin failed++; $display("FAIL mis_no_stall got %b want 0", o_stall); end
        @(negedge clk);
        set_nop();
        tests_run++;
        if (o_misaligned !== 1'b1 || o_RegWrite !== 1'b0 || o_alu_data !== 32'h13) begin
            failed++; $display("FAIL mis_pulse got mis=%b rw=%b alu=%h want 1 0 13", o_misaligned, o_RegWrite, o_alu_data);
        end
        @(negedge clk);
        tests_run++;
        if (o_misaligned !== 1'b0) begin failed++; $display("FAIL mis_one_cycle got %b want 0", o_misaligned); end
        do_store(32'h31, 32'h0000BEEF, 3'b001);
        do_load(32'h30, 3'b011, 5'd11, model_read(32'h30, 3'b011), "sh_mis_unchanged");
    endtask

    task automatic test_debug();
        do_store(32'h10, 32'hCAFEF00D, 3'b011);
        enable = 1'b0; i_debug_read_req = 1'b1; i_debug_read_address = 10'd4;
        @(negedge clk);
        i_debug_read_req = 1'b0;
        for (int k = 0; k <= L + 1; k++) begin
            tests_run++;
            if (o_debug_read_valid !== (k == L)) begin
                failed++; $display("FAIL dbg_valid k=%0d got %b want %b", k, o_debug_read_valid, (k == L));
            end
            @(negedge clk);
        end
        tests_run++;
        if (o_debug_read_data !== 32'hCAFEF00D) begin
            failed++; $display("FAIL dbg_data got %h want cafef00d", o_debug_read_data);
        end
        set_nop();
        i_debug_read_req = 1'b1; i_debug_read_address = 10'd8;
        for (int k = 0; k < L + 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (o_debug_read_valid !== 1'b0) begin failed++; $display("FAIL dbg_ignored got %b want 0", o_debug_read_valid); end
        end
        set_nop();
    endtask

    task automatic test_enable_hold();
        int ns;
        i_alu_data = 32'h20; i_ls_filter_op = 3'b011; i_rd = 5'd12;
        i_MemRead = 1'b1; i_RegWrite = 1'b1; i_MemtoReg = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (o_stall !== 1'b0 || o_RegWrite !== 1'b0) begin
                failed++; $display("FAIL hold_frozen got stall=%b rw=%b want 0 0", o_stall, o_RegWrite);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        ns = 0;
        #1;
        while (o_stall === 1'b1 && ns < 20) begin ns++; @(negedge clk); #1; end
        @(negedge clk);
        set_nop();
        tests_run++;
        if (o_mem_data !== model_read(32'h20, 3'b011) || o_rd !== 5'd12 || o_RegWrite !== 1'b1) begin
            failed++; $display("FAIL hold_resume got %h rd=%0d want %h rd=12", o_mem_data, o_rd, model_read(32'h20, 3'b011));
        end
    endtask

    task automatic test_reset_mid_load();
        i_alu_data = 32'h10; i_ls_filter_op = 3'b011; i_rd = 5'd13;
        i_MemRead = 1'b1; i_RegWrite = 1'b1; i_MemtoReg = 1'b1;
        @(negedge clk);
        rst = 1'b1; set_nop();
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({o_alu_data, o_mem_data, o_rd, o_RegWrite, o_stall} !== '0) begin
            failed++; $display("FAIL rst_mid_load got alu=%h mem=%h rd=%0d rw=%b stall=%b want 0", o_alu_data, o_mem_data, o_rd, o_RegWrite, o_stall);
        end
        for (int k = 0; k < L + 2; k++) begin
            @(negedge clk);
            tests_run++;
            if (o_RegWrite !== 1'b0) begin failed++; $display("FAIL rst_no_wb got %b want 0", o_RegWrite); end
        end
        do_load(32'h10, 3'b011, 5'd14, model_read(32'h10, 3'b011), "after_rst");
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [2:0]  op;
        int r, sz;
        for (int w = 0; w < 16; w++) do_store(32'h100 + 32'(4 * w), $urandom, 3'b011);
        for (int it = 0; it < 40; it++) begin
            r  = $urandom_range(0, 9);
            sz = $urandom_range(0, 2);
            op = (sz == 2) ? 3'b011 : {1'($urandom_range(0, 1)), 1'b0, 1'(sz)};
            a  = 32'h100 + 32'($urandom_range(0, 63));
            a  = a & ~(32'(nbytes(op)) - 1);
            d  = $urandom;
            if (r < 4) begin
                do_store(a, d, op);
            end else if (r < 9) begin
                do_load(a, op, 5'($urandom_range(1, 31)), model_read(a, op), "rand_load");
            end else begin
                i_alu_data = a | 32'h1; i_ls_filter_op = 3'b011; i_MemRead = 1'b1; i_RegWrite = 1'b1;
                @(negedge clk);
                set_nop();
                tests_run++;
                if (o_misaligned !== 1'b1 || o_RegWrite !== 1'b0) begin
                    failed++; $display("FAIL rand_mis got mis=%b rw=%b want 1 0", o_misaligned, o_RegWrite);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        set_nop();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_passthru();
        test_word_and_lanes();
        test_misaligned();
        test_debug();
        test_enable_hold();
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
